// File: rtl/rvr32_if.sv
// rvr32_if: RV32 instruction fetch stage. Requests are issued under a credit rule,
// responses fill an in-order instruction buffer, and redirects flush it.
module rvr32_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = PW + 3;

    logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, count_q, count_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_inst_q [DEPTH];
    logic [SW-1:0] credit;
    logic          grant, rsp_any, rsp_drop, wr, rd;

    // Every slot already spoken for (buffered, in flight, or awaiting discard) counts against DEPTH,
    // so an accepted response always has room in the buffer.
    assign credit     = SW'(count_q) + SW'(outst_q) + SW'(drop_q);
    assign imem_req   = !rst && !redirect && (credit < SW'(DEPTH));
    assign imem_addr  = fetch_pc_q & ~32'h3;
    assign grant      = imem_req && imem_gnt;
    assign rsp_any    = imem_rvalid && (outst_q != '0 || drop_q != '0);
    assign rsp_drop   = imem_rvalid && drop_q != '0;
    assign wr         = imem_rvalid && drop_q == '0 && outst_q != '0 && !redirect;
    assign rd         = inst_valid && inst_ready;
    assign inst_valid = count_q != '0;
    assign inst       = inst_valid ? fifo_inst_q[head_q] : '0;
    assign inst_pc    = inst_valid ? fifo_pc_q[head_q] : '0;

    // Next state: a redirect flushes the buffer and turns every in-flight request into a discard.
    always_comb begin
        fetch_pc_d = redirect ? (redirect_pc & ~32'h3) : (grant ? fetch_pc_q + 32'd4 : fetch_pc_q);
        resp_pc_d  = redirect ? (redirect_pc & ~32'h3) : (wr ? resp_pc_q + 32'd4 : resp_pc_q);
        outst_d    = redirect ? '0 : outst_q + CW'(grant) - CW'(wr);
        drop_d     = redirect ? drop_q + outst_q - CW'(rsp_any) : drop_q - CW'(rsp_drop);
        head_d     = redirect ? '0 : head_q + PW'(rd);
        tail_d     = redirect ? '0 : tail_q + PW'(wr);
        count_d    = redirect ? '0 : count_q + CW'(wr) - CW'(rd);
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Buffer storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (wr) begin
            fifo_pc_q[tail_q]   <= resp_pc_q;
            fifo_inst_q[tail_q] <= imem_rdata;
        end
    end

    // Protocol and capacity checks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(wr && !rd && count_q == CW'(DEPTH)))
                else $error("rvr32_if: instruction buffer overflow");
            assert (!(imem_rvalid && outst_q == '0 && drop_q == '0))
                else $error("rvr32_if: response with no request outstanding");
        end
    end
endmodule
